// File: rtl/fruit_spawn_scheduler_pkg.sv
// Shared types and widths for the fruit spawner and the object slots it feeds.
package fruit_spawn_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_PICK,
    ST_LAUNCH
  } spawn_state_t;

  localparam int FRUIT_KINDS = 8;
  localparam int FRUIT_W     = $clog2(FRUIT_KINDS);
  localparam int GAP_W       = 6;
  localparam int VEL_W       = 10;
  localparam int POS_W       = 10;

  // Screen x position for a 5-bit random value: 0..620 in steps of 20.
  function automatic logic [POS_W-1:0] rand_to_posx(input logic [4:0] r);
    return POS_W'(r) * POS_W'(20);
  endfunction

endpackage

// File: rtl/fruit_spawn_scheduler_rr_idle_pick.sv
// Round-robin search for the first idle slot at or above rr_ptr, wrapping around.
// Purely combinational; found is low when every slot is busy.
module rr_idle_pick #(
  parameter int SLOTS = 4,
  parameter int IDX_W = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0] slot_busy,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] sel_idx,
  output logic [SLOTS-1:0] sel_onehot
);

  int idx;

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    idx     = 0;
    // Walk offsets from farthest to nearest so the nearest idle slot wins.
    for (int k = SLOTS - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= SLOTS) idx = idx - SLOTS;
      if (!slot_busy[idx]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(idx);
      end
    end
    sel_onehot = found ? (SLOTS'(1) << sel_idx) : '0;
  end

endmodule

// File: rtl/fruit_spawn_scheduler.sv
// Spawns fruits into free slots after a randomized tick gap, capping airborne count.
// Launch pulses 2 clk after the gap expires when a slot is free; otherwise waits in PICK.
module fruit_spawn_scheduler
  import fruit_spawn_scheduler_pkg::*;
#(
  parameter int SLOTS      = 4,
  parameter int MAX_ACTIVE = 3,
  parameter int BASE_GAP   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               tick,
  input  logic [4:0]         randn,
  input  logic [SLOTS-1:0]   slot_busy,
  output logic [SLOTS-1:0]   launch,
  output logic [FRUIT_W-1:0] launch_fruit,
  output logic [POS_W-1:0]   launch_posx,
  output logic [VEL_W-1:0]   launch_vx,
  output logic [VEL_W-1:0]   launch_vy,
  output logic               launch_dx,
  output logic [3:0]         active_count,
  output logic [7:0]         launches_total
);

  localparam int               IDX_W    = $clog2(SLOTS);
  localparam logic [3:0]       MAX_ACT  = 4'(MAX_ACTIVE);
  localparam logic [GAP_W-1:0] GAP_BASE = GAP_W'(BASE_GAP);

  spawn_state_t     state, state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [SLOTS-1:0] sel_onehot;
  logic             found;
  logic             eligible;
  logic             do_launch;
  logic [3:0]       busy_cnt;

  rr_idle_pick #(.SLOTS(SLOTS)) u_pick (
    .slot_busy  (slot_busy),
    .rr_ptr     (rr_ptr),
    .found      (found),
    .sel_idx    (sel_idx),
    .sel_onehot (sel_onehot)
  );

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < SLOTS; i++) busy_cnt = busy_cnt + {3'b000, slot_busy[i]};
  end

  // Eligibility uses the registered count, so a freed slot is seen one cycle late.
  assign eligible  = found && (active_count < MAX_ACT);
  assign do_launch = (state == ST_PICK) && enable && eligible;

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (enable) state_nxt = ST_ARM;
      ST_ARM:    state_nxt = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable)           state_nxt = ST_IDLE;
        else if (gap_cnt == 0) state_nxt = ST_PICK;
      end
      ST_PICK: begin
        if (!enable)       state_nxt = ST_IDLE;
        else if (eligible) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: state_nxt = enable ? ST_ARM : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Launch, pointer and total are committed on entry to LAUNCH so they are
  // already valid while the launch pulse is high.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      gap_cnt        <= '0;
      rr_ptr         <= '0;
      launch         <= '0;
      launch_fruit   <= '0;
      launch_posx    <= '0;
      launch_vx      <= '0;
      launch_vy      <= '0;
      launch_dx      <= 1'b0;
      active_count   <= '0;
      launches_total <= '0;
    end else begin
      launch       <= '0;
      active_count <= busy_cnt;
      if (state == ST_ARM) gap_cnt <= GAP_BASE + GAP_W'(randn[3:0]);
      if (state == ST_WAIT && tick && gap_cnt != 0) gap_cnt <= gap_cnt - 1'b1;
      if (do_launch) begin
        launch         <= sel_onehot;
        launch_fruit   <= randn[4:2];
        launch_posx    <= rand_to_posx(randn);
        launch_vx      <= VEL_W'(randn % 5'd7);
        launch_vy      <= VEL_W'(randn[2:0]) + VEL_W'(8);
        launch_dx      <= randn[0];
        rr_ptr         <= (sel_idx == IDX_W'(SLOTS - 1)) ? '0 : sel_idx + 1'b1;
        launches_total <= launches_total + 8'd1;
      end
    end
  end

endmodule

// File: doc/fruit_spawn_scheduler.md
# fruit_spawn_scheduler

Sequences fruit launches across a pool of object slots, each slot being one object state machine plus its motion and display path. It decides when the next fruit spawns, which free slot receives it, and the randomized launch parameters, and it caps how many fruits are airborne at once. It sits between the random number generator and the slot array, and replaces per-slot random restart.

## Interface
- `SLOTS`, default 4: number of object slots, 2..8.
- `MAX_ACTIVE`, default 3: maximum simultaneously busy slots, 1..`SLOTS`.
- `BASE_GAP`, default 16: minimum spawn gap in ticks, 1..47.
- `clk` in 1: system clock; the only clock.
- `rstn` in 1: synchronous, active-low reset.
- `enable` in 1: game running; low parks the scheduler.
- `tick` in 1: one-`clk` pulse per frame; all gaps are counted in ticks.
- `randn` in 5: free-running random value, sampled in PICK.
- `slot_busy` in `SLOTS`: bit i high while slot i's object is in flight.
- `launch` out `SLOTS`: one-hot, one-cycle pulse that starts slot i.
- `launch_fruit` out 3: fruit select, valid with `launch` and held until the next launch.
- `launch_posx` out 10: initial x position, valid and held like `launch_fruit`.
- `launch_vx` out 10, `launch_vy` out 10, `launch_dx` out 1: initial velocity and x direction, valid and held like `launch_fruit`.
- `active_count` out 4: registered popcount of `slot_busy`.
- `launches_total` out 8: wrapping launch counter.

## Operation
- **States:** IDLE, ARM, WAIT, PICK, LAUNCH.
- **IDLE:** `launch` = 0. Go to ARM when `enable` = 1.
- **ARM:** load the 6-bit `gap_cnt` with `BASE_GAP + randn[3:0]`, then go to WAIT.
- **WAIT:** on each `tick`, decrement `gap_cnt`. When `gap_cnt` = 0, go to PICK. No `tick` means hold.
- **PICK:**
  - Eligible when `active_count < MAX_ACTIVE` and at least one slot_busy bit is 0.
  - When eligible, select the first idle slot searching upward from `rr_ptr` with wrap-around.
  - In the same cycle, register the launch parameters from `randn`:
    - fruit = `randn[4:2]`
    - posx = `randn*20` (0..620)
    - vx = `randn % 7`
    - vy = `8 + randn[2:0]`
    - dx = `randn[0]`
  - Then go to LAUNCH. When not eligible, stay in PICK with no timeout.
- **LAUNCH:**
  - `launch[sel]` = 1 for exactly this cycle.
  - `rr_ptr` ← (sel+1) mod `SLOTS`.
  - `launches_total` increments, wrapping 255→0.
  - Go to ARM.
- **`enable` low:** in ARM, WAIT or PICK, go to IDLE next cycle with no launch. LAUNCH always completes and then goes to IDLE instead of ARM. Re-enabling restarts from ARM with a fresh gap.
- **Reset values** (`rstn` = 0 at a clock edge, any state, including mid-LAUNCH, which truncates the pulse):
  - State is IDLE; `rr_ptr` = 0; `gap_cnt` = 0.
  - `launch` = 0; all `launch_*` = 0.
  - `active_count` = 0; `launches_total` = 0.
- **Slot contract:** a slot raises `slot_busy` within 2 `clk` of its `launch`. Because the gap is at least 1 tick, a just-launched slot is never re-picked.

## Timing
- `active_count` lags `slot_busy` by 1 cycle. PICK uses the registered value.
- Latency from `gap_cnt` reaching 0 to the `launch` pulse is 2 cycles when eligible (PICK, then LAUNCH).
- Launch parameters change only in the PICK cycle that leads to a launch. They are stable during and after the `launch` pulse.
- Minimum launch spacing is `BASE_GAP` ticks + 2 clk; maximum with a free slot is `BASE_GAP`+15 ticks + 2 clk.
- `tick` and the PICK eligibility check may coincide; each is evaluated only in its own state.

## Structure
- **Shared package** holds:
  - the state enum;
  - `FRUIT_KINDS` = 8;
  - the gap counter width (6);
  - the velocity and position widths (10), shared with the object slots.
- **Sub-module `rr_idle_pick`:** combinational search that takes `slot_busy` and `rr_ptr` and returns `found` plus a one-hot/index `sel`. It is reused by any future slot allocator.
- The FSM, counters and parameter registers live in the top.

## Test plan
All scenarios use `SLOTS`=4, `MAX_ACTIVE`=3, `BASE_GAP`=16, `tick` every 10 clk, and each slot's `slot_busy` rising 1 clk after its launch unless stated otherwise.
1. **Reset values:** hold `rstn` = 0 for 3 cycles → every output is 0 and state is IDLE.
2. **First launch:** `enable` = 1, `randn` = 5 constant, all slots idle → `launch` = 0001 after 21 ticks + 2 clk, with:
   - fruit = 1, posx = 100, vx = 5, vy = 13, dx = 1;
   - `launches_total` = 1.
3. **Round-robin order:** slots stay busy after launch → next launches are 0010 then 0100; the fourth launch waits in PICK because `active_count` = 3.
4. **Cap release:** continue from scenario 3, then drop `slot_busy[1]` → within 2 cycles `launch` = 1000 (search starts from `rr_ptr` = 3, so slot 3 is chosen).
5. **Disable mid-gap:** drop `enable` during WAIT with `gap_cnt` = 7 → no launch, IDLE next cycle. Re-enable → full new gap is loaded in ARM.
6. **Reset and counter wrap:**
   - Assert `rstn` = 0 during PICK → no launch and `rr_ptr` = 0.
   - Separately, run 256 launches with slots cleared after each → `launches_total` wraps to 0.
